gpio_in_conditioner: RTL and testbench



---
 rtl/gpio_cond_pkg.sv | 23 ++
 rtl/gpio_debounce_bit.sv | 60 ++++++
 rtl/gpio_in_conditioner.sv | 121 ++++++++++++
 tb/tb_gpio_in_conditioner.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_cond_pkg
//  Description : Shared defaults and event payload type for the GPIO input
//                conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_cond_pkg;

    localparam int c_DEF_WIDTH           = 8;
    localparam int c_DEF_SYNC_STAGES     = 2;
    localparam int c_DEF_DEBOUNCE_CYCLES = 4;

    // Wide enough for the largest supported pin count (34).
    localparam int c_IDX_W = 6;

    typedef struct packed {
        logic [c_IDX_W-1:0] index;
        logic               rising;
    } gpio_evt_t;

endpackage
`default_nettype wire

// File: rtl/gpio_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce_bit
//  Description : Single-pin synchronizer, debounce counter, level and edge
//                pulse generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = c_DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_level_prev;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // level_prev also freezes while disabled so a pending pulse survives the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= '0;
            r_cnt        <= '0;
            r_level      <= 1'b0;
            r_level_prev <= 1'b0;
        end else if (i_en) begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_level_prev <= r_level;
            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = i_en &  r_level & ~r_level_prev;
    assign o_fall  = i_en & ~r_level &  r_level_prev;

endmodule
`default_nettype wire

// File: rtl/gpio_in_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_in_conditioner
//  Description : Debounces raw GPIO pins, emits edge pulses and queues edge
//                events per pin onto a valid/ready port with overrun flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int WIDTH           = c_DEF_WIDTH,
    parameter int SYNC_STAGES     = c_DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    localparam int IW             = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] pin_in,
    input  logic             clear_overrun,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IW-1:0]    evt_index,
    output logic             evt_rising,
    output logic [WIDTH-1:0] overrun
);

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .i_en    (en),
            .i_pin   (pin_in[i]),
            .o_level (level_out[i]),
            .o_rise  (w_rise[i]),
            .o_fall  (w_fall[i])
        );
    end

    logic [WIDTH-1:0] r_pend_rise;
    logic [WIDTH-1:0] r_pend_fall;
    logic [WIDTH-1:0] r_overrun;
    logic             r_valid;
    gpio_evt_t        r_slot;

    logic             w_load;
    logic             w_any;
    gpio_evt_t        w_pick;
    logic [WIDTH-1:0] w_take_rise;
    logic [WIDTH-1:0] w_take_fall;
    logic [WIDTH-1:0] w_keep_rise;
    logic [WIDTH-1:0] w_keep_fall;
    logic             w_unused_idx;

    assign w_load = en & (~r_valid | evt_ready);

    // Scan downwards so the lowest pending index wins; rise beats fall per pin.
    always_comb begin
        w_any       = 1'b0;
        w_pick      = '0;
        w_take_rise = '0;
        w_take_fall = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pend_rise[i] | r_pend_fall[i]) begin
                w_any          = 1'b1;
                w_pick.index   = c_IDX_W'(i);
                w_pick.rising  = r_pend_rise[i];
                w_take_rise    = '0;
                w_take_fall    = '0;
                w_take_rise[i] = r_pend_rise[i];
                w_take_fall[i] = ~r_pend_rise[i];
            end
        end
        if (!w_load) begin
            w_take_rise = '0;
            w_take_fall = '0;
        end
    end

    assign w_keep_rise = r_pend_rise & ~w_take_rise;
    assign w_keep_fall = r_pend_fall & ~w_take_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_rise <= '0;
            r_pend_fall <= '0;
            r_overrun   <= '0;
            r_valid     <= 1'b0;
            r_slot      <= '0;
        end else if (en) begin
            r_pend_rise <= w_keep_rise | w_rise;
            r_pend_fall <= w_keep_fall | w_fall;
            r_overrun   <= (clear_overrun ? '0 : r_overrun)
                         | (w_rise & w_keep_rise) | (w_fall & w_keep_fall);
            if (w_load) begin
                r_valid <= w_any;
                r_slot  <= w_pick;
            end
        end
    end

    assign w_unused_idx = ^r_slot.index;

    assign rise_pulse = w_rise;
    assign fall_pulse = w_fall;
    assign evt_valid  = en & r_valid;
    assign evt_index  = r_slot.index[IW-1:0];
    assign evt_rising = r_slot.rising;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_in_conditioner
//  Description : Self-checking bench with an event-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_in_conditioner;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic         clk = 1'b0;
    logic         rst, en, clr, ready;
    logic [W-1:0] pin;
    logic [W-1:0] level_out, rise_pulse, fall_pulse, overrun;
    logic         evt_valid, evt_rising;
    logic [2:0]   evt_index;

    int n_chk  = 0;
    int n_fail = 0;

    gpio_in_conditioner #(
        .WIDTH           (W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .pin_in        (pin),
        .clear_overrun (clr),
        .level_out     (level_out),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .evt_valid     (evt_valid),
        .evt_ready     (ready),
        .evt_index     (evt_index),
        .evt_rising    (evt_rising),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: time advances only on enabled cycles; a level is accepted
    // once the synchronized input has disagreed with it for DEB enabled cycles.
    logic [W-1:0] m_sq [SYNC];
    int           m_run [W];
    logic [W-1:0] m_lvl, m_prev, m_pr, m_pf, m_ovr;
    logic         m_v, m_rise;
    int           m_idx;

    task automatic model_step();
        logic [W-1:0] rp, fp, take_r, take_f, nr, nf, synced;
        if (rst) begin
            for (int k = 0; k < SYNC; k++) m_sq[k] = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_lvl = '0; m_prev = '0; m_pr = '0; m_pf = '0; m_ovr = '0;
            m_v = 1'b0; m_rise = 1'b0; m_idx = 0;
            return;
        end
        if (!en) return;
        rp = m_lvl & ~m_prev;
        fp = ~m_lvl & m_prev;
        take_r = '0;
        take_f = '0;
        if (!m_v || ready) begin
            m_v = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (m_pr[i] || m_pf[i]) begin
                    m_v = 1'b1; m_idx = i; m_rise = m_pr[i];
                    if (m_pr[i]) take_r[i] = 1'b1; else take_f[i] = 1'b1;
                    break;
                end
            end
        end
        nr = m_pr & ~take_r;
        nf = m_pf & ~take_f;
        m_ovr = (clr ? '0 : m_ovr) | (rp & nr) | (fp & nf);
        m_pr = nr | rp;
        m_pf = nf | fp;
        synced = m_sq[SYNC-1];
        m_prev = m_lvl;
        for (int i = 0; i < W; i++) begin
            if (synced[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        for (int k = SYNC - 1; k > 0; k--) m_sq[k] = m_sq[k-1];
        m_sq[0] = pin;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        chk("level", 32'(level_out), 32'(m_lvl));
        chk("rise", 32'(rise_pulse), en ? 32'(m_lvl & ~m_prev) : 32'd0);
        chk("fall", 32'(fall_pulse), en ? 32'(~m_lvl & m_prev) : 32'd0);
        chk("valid", 32'(evt_valid), 32'(en & m_v));
        if (en && m_v) begin
            chk("index", 32'(evt_index), 32'(m_idx));
            chk("rising", 32'(evt_rising), 32'(m_rise));
        end
        chk("overrun", 32'(overrun), 32'(m_ovr));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int maxc);
        int k = 0;
        while (!evt_valid && k < maxc) begin
            step(1);
            k++;
        end
        chk("wait_valid", 32'(evt_valid), 32'd1);
    endtask

    logic [3:0] evq[$];
    logic [W-1:0] seen;

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; ready = 1'b0; pin = '0;
        step(3);
        chk("rst_level", 32'(level_out), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_index", 32'(evt_index), 32'd0);
        chk("rst_rising", 32'(evt_rising), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        // Single press latency
        ready = 1'b1;
        pin[3] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step(1);
            if (e == 5) chk("t1_level_early", 32'(level_out[3]), 32'd0);
            if (e == 6) begin
                chk("t1_level", 32'(level_out[3]), 32'd1);
                chk("t1_rise", 32'(rise_pulse), 32'h08);
            end
            if (e == 7) chk("t1_rise_gone", 32'(rise_pulse), 32'd0);
            if (e == 8) begin
                chk("t1_valid", 32'(evt_valid), 32'd1);
                chk("t1_index", 32'(evt_index), 32'd3);
                chk("t1_rising", 32'(evt_rising), 32'd1);
            end
            if (e == 9) chk("t1_valid_drop", 32'(evt_valid), 32'd0);
        end
        pin[3] = 1'b0;
        step(12);

        // Bounce shorter than the debounce window
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            pin[5] = ~pin[5];
            step(1);
            seen = seen | level_out | rise_pulse | fall_pulse | {7'd0, evt_valid};
        end
        for (int k = 0; k < 10; k++) begin
            step(1);
            seen = seen | level_out | rise_pulse | fall_pulse | {7'd0, evt_valid};
        end
        chk("t2_quiet", 32'(seen), 32'd0);

        // Ordering and stall
        ready = 1'b0;
        pin[1] = 1'b1; pin[6] = 1'b1;
        wait_valid(20);
        chk("t3_first", 32'(evt_index), 32'd1);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("t3_hold", 32'(evt_index), 32'd1);
        end
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        chk("t3_second", 32'(evt_index), 32'd6);
        chk("t3_second_rise", 32'(evt_rising), 32'd1);
        ready = 1'b1;
        step(1);
        chk("t3_empty", 32'(evt_valid), 32'd0);
        pin[1] = 1'b0; pin[6] = 1'b0;
        step(15);

        // Overrun while the slot is stalled
        ready = 1'b0;
        pin[0] = 1'b1;
        wait_valid(20);
        pin[2] = 1'b1; step(8);
        pin[2] = 1'b0; step(8);
        pin[2] = 1'b1; step(8);
        chk("t4_overrun", 32'(overrun), 32'h04);
        ready = 1'b1;
        evq.delete();
        for (int k = 0; k < 12; k++) begin
            if (evt_valid) evq.push_back({evt_index, evt_rising});
            step(1);
        end
        chk("t4_count", 32'(evq.size()), 32'd3);
        if (evq.size() == 3) begin
            chk("t4_ev0", 32'(evq[0]), 32'h1);
            chk("t4_ev1", 32'(evq[1]), 32'h5);
            chk("t4_ev2", 32'(evq[2]), 32'h4);
        end
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("t4_cleared", 32'(overrun), 32'd0);
        pin[0] = 1'b0; pin[2] = 1'b0;
        step(15);

        // Enable freeze mid-debounce
        ready = 1'b1;
        pin[4] = 1'b1;
        step(3);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t5_valid_off", 32'(evt_valid), 32'd0);
        end
        en = 1'b1;
        wait_valid(20);
        chk("t5_index", 32'(evt_index), 32'd4);
        chk("t5_level", 32'(level_out[4]), 32'd1);
        pin[4] = 1'b0;
        step(15);

        // Reset with events in flight
        ready = 1'b0;
        pin[1] = 1'b1; pin[2] = 1'b1; pin[3] = 1'b1;
        step(12);
        chk("t6_valid", 32'(evt_valid), 32'd1);
        rst = 1'b1; pin = '0;
        step(1);
        rst = 1'b0;
        chk("t6_level", 32'(level_out), 32'd0);
        chk("t6_valid0", 32'(evt_valid), 32'd0);
        chk("t6_overrun", 32'(overrun), 32'd0);
        ready = 1'b1;
        seen = '0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            seen[0] = seen[0] | evt_valid;
        end
        chk("t6_no_stale", 32'(seen[0]), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 5) == 0) pin = pin ^ (W'(1) << $urandom_range(0, W - 1));
            en    = ($urandom_range(0, 15) != 0);
            ready = ($urandom_range(0, 2) != 0);
            clr   = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst = 1'b0; en = 1'b1; clr = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
